perceptron_neuron: RTL

Sequential single-neuron perceptron datapath built on the team's 6-bit fixed-point arithmetic primitives. Holds a weight bank and bias, accepts one feature per handshake, multiplies each feature by its weight, accumulates with saturation, and emits a thresholded classification plus the raw sum. Sits between the feature-streaming front end (upstream) and the classification/result register stage (downstream).

---
 rtl/perceptron_neuron_if.sv | 32 +++
 rtl/perceptron_neuron.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/perceptron_neuron_if.sv
// Handshake bundle between the feature front end (master) and the perceptron neuron (slave).
// Carries the weight-write port, the feature stream and the classification result.
interface perceptron_neuron_if #(
    parameter int N_INPUTS = 4,
    parameter int WIDTH    = 6,
    parameter int ACC_W    = 10
) ();
    localparam int AW = $clog2(N_INPUTS + 1);

    logic             w_we;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             w_ready;
    logic [ACC_W-1:0] threshold;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_class;
    logic [ACC_W-1:0] out_sum;

    modport master (
        output w_we, w_addr, w_data, threshold, in_valid, in_data, out_ready,
        input  w_ready, in_ready, out_valid, out_class, out_sum
    );

    modport slave (
        input  w_we, w_addr, w_data, threshold, in_valid, in_data, out_ready,
        output w_ready, in_ready, out_valid, out_class, out_sum
    );
endinterface

// File: rtl/perceptron_neuron.sv
// Single perceptron: one feature per cycle, saturating MAC; result registered 1 cycle after last feature.
// Result held in OUT until out_ready; no features or weight writes accepted while a result is pending.
module perceptron_neuron #(
    parameter int N_INPUTS = 4,
    parameter int WIDTH    = 6,
    parameter int FRAC     = 3,
    parameter int ACC_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    perceptron_neuron_if.slave bus
);
    localparam int CNT_W = $clog2(N_INPUTS);
    localparam int AW    = $clog2(N_INPUTS + 1);
    localparam int PW    = 2 * WIDTH - FRAC;
    localparam int SW    = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_class_q, out_class_d;
    logic [WIDTH-1:0] weight_q [N_INPUTS];
    logic [WIDTH-1:0] weight_d [N_INPUTS];
    logic [WIDTH-1:0] bias_q, bias_d;

    logic [WIDTH-1:0]   w_sel;
    logic [2*WIDTH-1:0] prod_full;
    logic [PW-1:0]      prod;
    logic [ACC_W-1:0]   acc_base;
    logic [SW-1:0]      acc_sum;
    logic [ACC_W-1:0]   acc_sat;
    logic               feat_acc;
    logic               last_feat;
    logic               wr_acc;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (count_q == CNT_W'(i)) begin
                w_sel = weight_q[i];
            end
        end
    end

    // Full-precision product; only the fractional bits are dropped.
    assign prod_full = {{WIDTH{1'b0}}, bus.in_data} * {{WIDTH{1'b0}}, w_sel};
    assign prod      = PW'(prod_full >> FRAC);

    // The first feature of a sample starts from the bias, never from stale accumulator state.
    assign acc_base  = (count_q == '0) ? ACC_W'(bias_q) : acc_q;
    assign acc_sum   = {1'b0, acc_base} + SW'(prod);
    assign acc_sat   = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];

    assign feat_acc  = (state_q == ACCUM) && bus.in_valid;
    assign last_feat = (count_q == CNT_W'(N_INPUTS - 1));
    assign wr_acc    = bus.w_we && (state_q == ACCUM) && (count_q == '0);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_class_d = out_class_q;
        bias_d      = bias_q;
        for (int i = 0; i < N_INPUTS; i++) begin
            weight_d[i] = weight_q[i];
        end

        // Writes land next cycle, so a feature taken in the same cycle still sees the old value.
        if (wr_acc) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (bus.w_addr == AW'(i)) begin
                    weight_d[i] = bus.w_data;
                end
            end
            if (bus.w_addr == AW'(N_INPUTS)) begin
                bias_d = bus.w_data;
            end
        end

        case (state_q)
            ACCUM: begin
                if (feat_acc) begin
                    acc_d = acc_sat;
                    if (last_feat) begin
                        out_sum_d   = acc_sat;
                        out_class_d = (acc_sat >= bus.threshold);
                        count_d     = '0;
                        state_d     = OUT;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_class_q <= 1'b0;
            bias_q      <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_class_q <= out_class_d;
            bias_q      <= bias_d;
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_q[i] <= weight_d[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.w_ready   = (state_q == ACCUM) && (count_q == '0);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_class = out_class_q;

endmodule
